// File: rtl/ld_mem_resp_if.sv
//------------------------------------------------------------------------------
// Module   : ld_mem_resp_if
// Brief    : Load-port and committed-store bundle between load queue and responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ld_mem_resp_if;
    logic        flsh;
    logic        ld_req;
    logic [15:0] addr;
    logic        ld_grnt;
    logic        fwd_rdy;
    logic        fwd;
    logic [15:0] data_sq;
    logic        done;
    logic [15:0] data_ca;
    logic        st_vld;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_full;

    modport master (
        output flsh, ld_req, addr, st_vld, st_addr, st_data,
        input  ld_grnt, fwd_rdy, fwd, data_sq, done, data_ca, st_full
    );

    modport slave (
        input  flsh, ld_req, addr, st_vld, st_addr, st_data,
        output ld_grnt, fwd_rdy, fwd, data_sq, done, data_ca, st_full
    );
endinterface

`default_nettype wire

// File: rtl/ld_mem_resp.sv
//------------------------------------------------------------------------------
// Module   : ld_mem_resp
// Brief    : Load-port responder with store-to-load forwarding from a committed
//            store buffer that drains into a word-addressed data memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ld_mem_resp #(
    parameter int SB_DEPTH = 4,
    parameter int MEM_AW   = 8,
    parameter int LAT      = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ld_mem_resp_if.slave bus
);

    localparam int c_IW = $clog2(SB_DEPTH);
    localparam int c_PW = c_IW + 1;
    localparam int c_CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOOKUP = 3'd1;
    localparam logic [2:0] c_RESULT = 3'd2;
    localparam logic [2:0] c_ACCESS = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]      r_state;
    logic [15:0]     r_addr;
    logic            r_hit;
    logic [15:0]     r_fwd_data;
    logic [15:0]     r_ca_data;
    logic [c_CW-1:0] r_cnt;

    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [15:0]     r_sb_addr [SB_DEPTH];
    logic [15:0]     r_sb_data [SB_DEPTH];
    logic [15:0]     r_mem     [2**MEM_AW];

    logic [c_PW-1:0] w_count;
    logic            w_full;
    logic            w_push;
    logic            w_drain;
    logic            w_hit;
    logic [15:0]     w_hit_data;
    logic [c_IW-1:0] w_head_idx;
    logic [c_IW-1:0] w_tail_idx;

    assign w_count    = r_tail - r_head;
    assign w_full     = (w_count == c_PW'(SB_DEPTH));
    assign w_push     = bus.st_vld && !w_full;
    assign w_head_idx = r_head[c_IW-1:0];
    assign w_tail_idx = r_tail[c_IW-1:0];
    // A pending load request always wins the port over a drain.
    assign w_drain    = (r_state == c_IDLE) && (w_count != '0) && !bus.ld_req && !rst;

    // Walk oldest to youngest so the youngest matching entry is the one kept.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            logic [c_IW-1:0] idx;
            idx = w_head_idx + c_IW'(k);
            if ((c_PW'(k) < w_count) && (r_sb_addr[idx] == r_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_sb_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_hit      <= 1'b0;
            r_fwd_data <= '0;
            r_ca_data  <= '0;
            r_cnt      <= '0;
        end else if (bus.flsh) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.ld_req) begin
                        r_addr  <= bus.addr;
                        r_state <= c_LOOKUP;
                    end
                end
                c_LOOKUP: begin
                    r_hit      <= w_hit;
                    r_fwd_data <= w_hit_data;
                    r_state    <= c_RESULT;
                end
                c_RESULT: begin
                    if (r_hit) begin
                        r_ca_data <= r_fwd_data;
                        r_state   <= c_DONE;
                    end else begin
                        r_cnt   <= c_CW'(LAT - 1);
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_ca_data <= r_mem[r_addr[MEM_AW-1:0]];
                        r_state   <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push)  r_tail <= r_tail + 1'b1;
            if (w_drain) r_head <= r_head + 1'b1;
        end
    end

    // Entry storage and data memory carry no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[w_tail_idx] <= bus.st_addr;
            r_sb_data[w_tail_idx] <= bus.st_data;
        end
        if (w_drain) begin
            r_mem[r_sb_addr[w_head_idx][MEM_AW-1:0]] <= r_sb_data[w_head_idx];
        end
    end

    assign bus.ld_grnt = (r_state != c_IDLE);
    assign bus.fwd_rdy = (r_state == c_RESULT);
    assign bus.fwd     = r_hit;
    assign bus.data_sq = r_fwd_data;
    assign bus.done    = (r_state == c_DONE);
    assign bus.data_ca = r_ca_data;
    assign bus.st_full = w_full;

endmodule

`default_nettype wire

// File: tb/tb_ld_mem_resp.sv
//------------------------------------------------------------------------------
// Module   : tb_ld_mem_resp
// Brief    : Directed self-checking bench for ld_mem_resp with a load scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ld_mem_resp;

    localparam int LAT = 2;

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [15:0] sb [$];
    st_t         stq [$];

    ld_mem_resp_if bus_if ();

    ld_mem_resp #(
        .SB_DEPTH (4),
        .MEM_AW   (8),
        .LAT      (LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; queued store pushes are presented one per edge.
    task automatic tick();
        st_t s;
        if (stq.size() > 0) begin
            s = stq.pop_front();
            bus_if.st_vld  = s.v;
            bus_if.st_addr = s.a;
            bus_if.st_data = s.d;
        end else begin
            bus_if.st_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        bus_if.st_vld = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        stq.push_back({1'b1, a, d});
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] exp_data, input logic exp_hit);
        int n;
        int lat;
        logic [15:0] exp_ca;
        sb.push_back(exp_data);
        bus_if.ld_req = 1'b1;
        bus_if.addr   = a;
        n = 0;
        while (!bus_if.ld_grnt && n < 20) begin
            tick();
            n++;
        end
        check("grant_latency", n, 1);
        bus_if.ld_req = 1'b0;
        tick();
        check("fwd_rdy", {31'd0, bus_if.fwd_rdy}, 1);
        check("fwd", {31'd0, bus_if.fwd}, {31'd0, exp_hit});
        check("data_sq", {16'd0, bus_if.data_sq}, {16'd0, (exp_hit ? exp_data : 16'h0000)});
        lat = 0;
        while (!bus_if.done && lat < 20) begin
            tick();
            lat++;
        end
        check("done_latency", lat, exp_hit ? 1 : 1 + LAT);
        check("ld_grnt_in_done", {31'd0, bus_if.ld_grnt}, 1);
        if (sb.size() > 0) begin
            exp_ca = sb.pop_front();
            check("data_ca", {16'd0, bus_if.data_ca}, {16'd0, exp_ca});
        end else begin
            check("scoreboard_underflow", 1, 0);
        end
        tick();
        check("ld_grnt_after", {31'd0, bus_if.ld_grnt}, 0);
        check("done_pulse", {31'd0, bus_if.done}, 0);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus_if.flsh     = 1'b0;
        bus_if.ld_req   = 1'b0;
        bus_if.addr     = '0;
        bus_if.st_vld   = 1'b0;
        bus_if.st_addr  = '0;
        bus_if.st_data  = '0;

        tick();
        tick();
        rst = 1'b0;
        check("rst_ld_grnt", {31'd0, bus_if.ld_grnt}, 0);
        check("rst_fwd_rdy", {31'd0, bus_if.fwd_rdy}, 0);
        check("rst_fwd", {31'd0, bus_if.fwd}, 0);
        check("rst_data_sq", {16'd0, bus_if.data_sq}, 0);
        check("rst_done", {31'd0, bus_if.done}, 0);
        check("rst_data_ca", {16'd0, bus_if.data_ca}, 0);
        check("rst_st_full", {31'd0, bus_if.st_full}, 0);

        // Miss after drain.
        push(16'h0010, 16'hAAAA);
        tick(); tick(); tick();
        load(16'h0010, 16'hAAAA, 1'b0);

        // Two stores to one address: youngest forwarded.
        push(16'h0020, 16'h1111);
        tick();
        push(16'h0020, 16'h2222);
        load(16'h0020, 16'h2222, 1'b1);
        tick(); tick(); tick();
        load(16'h0020, 16'h2222, 1'b0);

        // Store pushed during LOOKUP is not seen; then priority over drain.
        stq.push_back({1'b0, 16'h0000, 16'h0000});
        push(16'h0010, 16'h5555);
        load(16'h0010, 16'hAAAA, 1'b0);
        load(16'h0010, 16'h5555, 1'b1);
        tick();
        load(16'h0010, 16'h5555, 1'b0);

        // Fill to full under back-to-back loads, fifth push rejected.
        push(16'h0050, 16'hB000);
        push(16'h0051, 16'hB001);
        push(16'h0052, 16'hB002);
        push(16'h0053, 16'hB003);
        push(16'h0050, 16'hDEAD);
        load(16'h0010, 16'h5555, 1'b0);
        check("st_full_set", {31'd0, bus_if.st_full}, 1);
        load(16'h0050, 16'hB000, 1'b1);
        load(16'h0053, 16'hB003, 1'b1);
        tick();
        check("st_full_clear", {31'd0, bus_if.st_full}, 0);
        tick(); tick(); tick();
        load(16'h0050, 16'hB000, 1'b0);
        load(16'h0051, 16'hB001, 1'b0);
        load(16'h0052, 16'hB002, 1'b0);
        load(16'h0053, 16'hB003, 1'b0);
        push(16'h0060, 16'hC0C0);
        load(16'h0060, 16'hC0C0, 1'b1);
        tick(); tick();

        // Flush in IDLE suppresses grant; flush in ACCESS abandons load.
        bus_if.flsh   = 1'b1;
        bus_if.ld_req = 1'b1;
        bus_if.addr   = 16'h0051;
        tick();
        check("flsh_idle_grant", {31'd0, bus_if.ld_grnt}, 0);
        bus_if.flsh = 1'b0;
        tick();
        check("flsh_grant", {31'd0, bus_if.ld_grnt}, 1);
        bus_if.ld_req = 1'b0;
        tick();
        check("flsh_fwd_rdy", {31'd0, bus_if.fwd_rdy}, 1);
        tick();
        bus_if.flsh = 1'b1;
        tick();
        bus_if.flsh = 1'b0;
        check("flsh_ld_grnt", {31'd0, bus_if.ld_grnt}, 0);
        check("flsh_done", {31'd0, bus_if.done}, 0);
        tick();
        check("flsh_done_late", {31'd0, bus_if.done}, 0);
        load(16'h0051, 16'hB001, 1'b0);

        // Reset during ACCESS with two stores buffered.
        push(16'h0050, 16'hEEEE);
        push(16'h0051, 16'hEEEE);
        bus_if.ld_req = 1'b1;
        bus_if.addr   = 16'h0052;
        tick();
        bus_if.ld_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ld_grnt", {31'd0, bus_if.ld_grnt}, 0);
        check("mid_rst_fwd_rdy", {31'd0, bus_if.fwd_rdy}, 0);
        check("mid_rst_fwd", {31'd0, bus_if.fwd}, 0);
        check("mid_rst_data_sq", {16'd0, bus_if.data_sq}, 0);
        check("mid_rst_done", {31'd0, bus_if.done}, 0);
        check("mid_rst_data_ca", {16'd0, bus_if.data_ca}, 0);
        check("mid_rst_st_full", {31'd0, bus_if.st_full}, 0);
        tick();
        tick();
        check("mid_rst_no_done", {31'd0, bus_if.done}, 0);
        load(16'h0050, 16'hB000, 1'b0);
        load(16'h0051, 16'hB001, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
